// File: rtl/seg_pkg.sv
// Shared seven-segment definitions used by both the encoder and the scan decoder.
// Segment codes are active-low, packed g..a (bit6 = g, bit0 = a).
package seg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    localparam seg_t SEG_0     = 7'b100_0000;
    localparam seg_t SEG_1     = 7'b111_1001;
    localparam seg_t SEG_2     = 7'b010_0100;
    localparam seg_t SEG_3     = 7'b011_0000;
    localparam seg_t SEG_4     = 7'b001_1001;
    localparam seg_t SEG_5     = 7'b001_0010;
    localparam seg_t SEG_6     = 7'b000_0010;
    localparam seg_t SEG_7     = 7'b101_1000;
    localparam seg_t SEG_8     = 7'b000_0000;
    localparam seg_t SEG_9     = 7'b001_0000;
    localparam seg_t SEG_BLANK = 7'b111_1111;

    // Value reported for a digit that has no legal decimal content.
    localparam bcd_t BCD_NONE  = 4'hF;

endpackage : seg_pkg

// File: rtl/seg_to_bcd.sv
// Combinational inverse of the BCD-to-segment encoder: one active-low
// segment pattern in, decimal value plus legal/blank classification out.
module seg_to_bcd
    import seg_pkg::*;
(
    input  seg_t i_seg,
    output bcd_t o_bcd,
    output logic o_legal,
    output logic o_blank
);

    // Table lookup; anything not in the table is neither legal nor blank.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which is what would otherwise infer a latch.
        o_bcd   = BCD_NONE;
        o_legal = 1'b1;
        o_blank = 1'b0;
        unique case (i_seg)
            SEG_0:     o_bcd = 4'd0;
            SEG_1:     o_bcd = 4'd1;
            SEG_2:     o_bcd = 4'd2;
            SEG_3:     o_bcd = 4'd3;
            SEG_4:     o_bcd = 4'd4;
            SEG_5:     o_bcd = 4'd5;
            SEG_6:     o_bcd = 4'd6;
            SEG_7:     o_bcd = 4'd7;
            SEG_8:     o_bcd = 4'd8;
            SEG_9:     o_bcd = 4'd9;
            SEG_BLANK: begin
                o_legal = 1'b0;
                o_blank = 1'b1;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule : seg_to_bcd

// File: rtl/seg_scan_decoder.sv
// Scanned seven-segment bus monitor: samples the multiplexed display bus,
// waits for STABLE_CYCLES identical samples, then captures the selected
// digit's decimal value, flags illegal patterns and reports full frames.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [NUM_DIGITS-1:0]   dig_sel_i,
    input  logic [6:0]              seg_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic [NUM_DIGITS-1:0]   valid_o,
    output logic                    err_o,
    output logic                    frame_o
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Sample registers and stability window state.
    logic [NUM_DIGITS-1:0]   r_sel;
    seg_t                    r_seg;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_done;

    // Captured outputs and frame tracking.
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    r_err;
    logic                    r_frame;

    // Combinational helpers.
    logic                    w_changed;
    logic                    w_fire;
    logic                    w_sel_zero;
    logic                    w_sel_multi;
    logic [NUM_DIGITS-1:0]   w_seen_upd;
    bcd_t                    w_dec_bcd;
    logic                    w_dec_legal;
    logic                    w_dec_blank;

    // Decode the sampled pattern; it is only consumed on a capture edge.
    seg_to_bcd u_seg_to_bcd (
        .i_seg   (r_seg),
        .o_bcd   (w_dec_bcd),
        .o_legal (w_dec_legal),
        .o_blank (w_dec_blank)
    );

    // Window control and select classification.
    always_comb begin
        w_changed   = (dig_sel_i != r_sel) || (seg_i != r_seg);
        // Capture happens once per stable window, only when the bus still
        // matches what was sampled and the counter has reached the end.
        w_fire      = !w_changed && en_i && (r_cnt == CNT_LAST) && !r_done;
        w_sel_zero  = (r_sel == '0);
        // Clearing the lowest set bit leaves something only if two or more are set.
        w_sel_multi = (r_sel & (r_sel - 1'b1)) != '0;
        // With a one-hot select the select itself is the bit to mark as seen.
        w_seen_upd  = r_seen | r_sel;
    end

    // Sampler: track the bus, count stable cycles, remember the capture.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // updates from the pre-edge values, independent of statement order.
        if (rst_i) begin
            r_sel  <= '0;
            r_seg  <= SEG_BLANK;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (w_changed) begin
            r_sel  <= dig_sel_i;
            r_seg  <= seg_i;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!en_i) begin
            r_cnt  <= '0;
        end else if (r_cnt != CNT_LAST) begin
            r_cnt  <= r_cnt + 1'b1;
        end else if (!r_done) begin
            r_done <= 1'b1;
        end
    end

    // Capture: update the selected digit, raise pulses, track the frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bcd   <= {NUM_DIGITS{BCD_NONE}};
            r_valid <= '0;
            r_seen  <= '0;
            r_err   <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_err   <= 1'b0;
            r_frame <= 1'b0;
            if (w_fire) begin
                if (w_sel_multi) begin
                    r_err <= 1'b1;
                end else if (!w_sel_zero) begin
                    for (int d = 0; d < NUM_DIGITS; d++) begin
                        if (r_sel[d]) begin
                            if (w_dec_legal) begin
                                r_bcd[4*d +: 4] <= w_dec_bcd;
                                r_valid[d]      <= 1'b1;
                            end else if (w_dec_blank) begin
                                r_bcd[4*d +: 4] <= BCD_NONE;
                                r_valid[d]      <= 1'b0;
                            end else begin
                                r_valid[d]      <= 1'b0;
                            end
                        end
                    end
                    if (!w_dec_legal && !w_dec_blank) begin
                        r_err <= 1'b1;
                    end
                    if (&w_seen_upd) begin
                        r_frame <= 1'b1;
                        r_seen  <= '0;
                    end else begin
                        r_seen  <= w_seen_upd;
                    end
                end
            end
        end
    end

    assign bcd_o   = r_bcd;
    assign valid_o = r_valid;
    assign err_o   = r_err;
    assign frame_o = r_frame;

endmodule : seg_scan_decoder

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with NUM_DIGITS=4, STABLE_CYCLES=4.
module tb_seg_scan_decoder;

    localparam logic [6:0] P1    = 7'b111_1001;
    localparam logic [6:0] P2    = 7'b010_0100;
    localparam logic [6:0] P3    = 7'b011_0000;
    localparam logic [6:0] P4    = 7'b001_1001;
    localparam logic [6:0] P5    = 7'b001_0010;
    localparam logic [6:0] P7    = 7'b101_1000;
    localparam logic [6:0] P8    = 7'b000_0000;
    localparam logic [6:0] P9    = 7'b001_0000;
    localparam logic [6:0] PBLK  = 7'b111_1111;
    localparam logic [6:0] PBAD  = 7'b000_0001;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [3:0]  dig_sel_i;
    logic [6:0]  seg_i;
    logic [15:0] bcd_o;
    logic [3:0]  valid_o;
    logic        err_o;
    logic        frame_o;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .dig_sel_i (dig_sel_i),
        .seg_i     (seg_i),
        .bcd_o     (bcd_o),
        .valid_o   (valid_o),
        .err_o     (err_o),
        .frame_o   (frame_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Hold the inputs for n edges, counting err/frame pulses.
    task automatic hold(input int n, output int n_err, output int n_frame);
        n_err   = 0;
        n_frame = 0;
        for (int i = 0; i < n; i++) begin
            step();
            n_err   += int'(err_o);
            n_frame += int'(frame_o);
        end
    endtask

    initial begin
        int e, f;
        logic [6:0] scan_pat [4];
        scan_pat[0] = P1; scan_pat[1] = P2; scan_pat[2] = P3; scan_pat[3] = P4;

        // 1. Reset
        rst_i = 1'b1; en_i = 1'b1; dig_sel_i = 4'b0000; seg_i = PBLK;
        step(); step();
        check("rst_bcd",   bcd_o,   32'hFFFF);
        check("rst_valid", valid_o, 32'h0);
        check("rst_err",   err_o,   32'h0);
        check("rst_frame", frame_o, 32'h0);
        rst_i = 1'b0;

        // 2. Single digit, capture latency
        dig_sel_i = 4'b0001; seg_i = P2;
        e = 0; f = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            e += int'(err_o); f += int'(frame_o);
            check($sformatf("lat_bcd0_e%0d", k),   bcd_o[3:0], (k >= 4) ? 32'h2 : 32'hF);
            check($sformatf("lat_valid0_e%0d", k), valid_o[0], (k >= 4) ? 32'h1 : 32'h0);
        end
        check("lat_err_cnt",   e, 0);
        check("lat_frame_cnt", f, 0);

        // 3. Full scan of four digits
        e = 0; f = 0;
        for (int d = 0; d < 4; d++) begin
            dig_sel_i = 4'b0001 << d; seg_i = scan_pat[d];
            for (int k = 0; k < 8; k++) begin
                step();
                e += int'(err_o); f += int'(frame_o);
                if (d == 3) begin
                    check($sformatf("scan_frame_e%0d", k), frame_o, (k == 4) ? 32'h1 : 32'h0);
                end
            end
        end
        check("scan_bcd",       bcd_o,   32'h4321);
        check("scan_valid",     valid_o, 32'hF);
        check("scan_frame_cnt", f, 1);
        check("scan_err_cnt",   e, 0);

        // 4. Short-lived pattern is not captured
        dig_sel_i = 4'b0010; seg_i = P4;
        hold(2, e, f);
        check("short_hold_bcd1", bcd_o[7:4], 32'h2);
        seg_i = P5;
        hold(3, e, f);
        check("short_pre_bcd1", bcd_o[7:4], 32'h2);
        hold(3, e, f);
        check("short_bcd1", bcd_o[7:4], 32'h5);
        check("short_err",  e, 0);

        // 5. Illegal pattern and multi-hot select, digit 1 holding 4
        seg_i = P4;
        hold(6, e, f);
        check("ill_setup_bcd1", bcd_o[7:4], 32'h4);
        seg_i = PBAD;
        hold(6, e, f);
        check("ill_err_cnt", e, 1);
        check("ill_valid",   valid_o, 32'b1101);
        check("ill_bcd",     bcd_o,   32'h4341);
        check("ill_frame",   f, 0);
        dig_sel_i = 4'b0011; seg_i = P8;
        hold(6, e, f);
        check("multi_err_cnt", e, 1);
        check("multi_bcd",     bcd_o,   32'h4341);
        check("multi_valid",   valid_o, 32'b1101);

        // 6a. Enable low blocks capture; raising it captures 4 edges later
        en_i = 1'b0; dig_sel_i = 4'b0100; seg_i = P7;
        hold(6, e, f);
        check("en_off_bcd2",  bcd_o[11:8], 32'h3);
        en_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("en_on_bcd2_e%0d", k), bcd_o[11:8], (k == 4) ? 32'h7 : 32'h3);
        end
        check("en_on_valid", valid_o, 32'b1101);

        // 6b. Reset mid-window
        dig_sel_i = 4'b1000; seg_i = P9;
        step(); step(); step();
        rst_i = 1'b1;
        step();
        check("mid_rst_bcd",   bcd_o,   32'hFFFF);
        check("mid_rst_valid", valid_o, 32'h0);
        hold(3, e, f);
        check("mid_rst_hold_bcd", bcd_o, 32'hFFFF);
        check("mid_rst_hold_pulses", e + f, 0);
        rst_i = 1'b0; dig_sel_i = 4'b0000; seg_i = PBLK;
        hold(8, e, f);
        check("post_rst_bcd",    bcd_o,   32'hFFFF);
        check("post_rst_valid",  valid_o, 32'h0);
        check("post_rst_pulses", e + f, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_seg_scan_decoder

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive side of the seven-segment display path: the inverse of the BCD-to-segment encoder.
- Samples a multiplexed, scanned display bus (one-hot digit select plus shared active-low segment lines) and rebuilds per-digit BCD values.
- Applies a stability filter before capturing, and flags illegal patterns.
- Used as a readback/monitor for the digital clock display and as a loopback checker in the board test.

Parameters:
- NUM_DIGITS, 4: number of scanned digits; must be >= 1.
- STABLE_CYCLES, 4: consecutive identical samples required before capture; must be >= 2.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- en_i  in  1  capture enable
- dig_sel_i  in  NUM_DIGITS  digit select, active-high, one-hot when driving
- seg_i  in  7  segment lines, active-low; bit0=a … bit6=g
- bcd_o  out  4*NUM_DIGITS  captured digits; digit d at [4d+3:4d]
- valid_o  out  NUM_DIGITS  digit d holds a legal decimal value
- err_o  out  1  one-cycle pulse on an illegal pattern or multi-hot select
- frame_o  out  1  one-cycle pulse once every digit has been captured since the last pulse

Behaviour:
- Reset (rst_i=1 at an edge):
  - bcd_o = all 4'hF; valid_o = 0; err_o = 0; frame_o = 0.
  - Seen-mask = 0; sample regs sel = 0, seg = 7'h7F; stability counter = 0; done = 0.
  - Reset mid-window discards the partial count. Reset has priority over all other logic.
- Sampling, at each edge:
  - If {dig_sel_i, seg_i} differs from the sample regs: load them, counter <= 0, done <= 0.
  - Otherwise, if counter != STABLE_CYCLES-1: counter increments.
- Capture:
  - Fires on the edge after counter == STABLE_CYCLES-1 with done=0; sets done=1, so there is exactly one capture per stable window.
  - Latency: a new input first sampled at edge 0 is visible on outputs after edge STABLE_CYCLES.
  - A change before capture restarts the window; no partial capture.
- Capture action, by sampled select:
  - Zero-hot (blanking gap): no update, no error.
  - Multi-hot: no update; err_o pulses.
  - One-hot digit d: decode seg.
- Decode table (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000
  - Legal pattern: bcd[d] <= value, valid[d] <= 1.
  - 1111111 (blank): bcd[d] <= 4'hF, valid[d] <= 0, no error.
  - Any other pattern: bcd[d] holds, valid[d] <= 0, err_o pulses.
- Frame tracking:
  - Every one-hot capture (legal, blank or illegal) sets seen[d].
  - When the updated mask is all ones: frame_o pulses in the same cycle as that capture, and the mask clears.
- Enable: en_i=0 holds the counter at 0 and blocks capture. Sample regs keep tracking. Outputs and mask hold.
- Pulses: err_o and frame_o are high for exactly one cycle per event and can be asserted together.

Decomposition:
- Shared package seg_pkg:
  - Constants SEG_0..SEG_9 and SEG_BLANK; the encoder uses the same values.
  - Segment-code typedef (7-bit) and BCD typedef (4-bit).
- One combinational sub-module, seg_to_bcd: 7-bit pattern in; 4-bit value, legal flag and blank flag out.
- Counter, capture, mask and output registers live in seg_scan_decoder.

Test Plan (NUM_DIGITS=4, STABLE_CYCLES=4):
1. Reset for 2 cycles -> bcd_o=16'hFFFF, valid_o=4'b0000, err_o=0, frame_o=0.
2. sel=0001, seg=0100100 held 8 cycles from edge 0 -> bcd_o[3:0]=2 and valid_o[0]=1 appear exactly after edge 4; no further events.
3. Scan digits 0..3 with 1111001, 0100100, 0110000, 0011001, 8 cycles each -> bcd_o=16'h4321, valid_o=4'hF; frame_o pulses once, coincident with the digit-3 capture.
4. sel=0010, seg=0011001 for 2 cycles, then 0010010 for 6 cycles -> only 5 is captured into digit 1; no capture of 4.
5. Two illegal cases, with digit 1 previously holding 4:
   - sel=0010, seg=0000001 for 6 cycles -> err_o pulses once; valid_o[1]=0; bcd_o[7:4] stays 4.
   - sel=0011 for 6 cycles -> err_o pulses once; no update.
6. Two interruption cases:
   - en_i=0 during a 6-cycle stable window -> no capture; raising en_i with the input still stable -> capture 4 cycles later.
   - rst_i asserted at count 2 -> all outputs return to reset values and no capture occurs.
